mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one main-memory block port between the I-cache (read-only) and D-cache (read/write) controllers.
//  Sits between both cache controllers and the memory; each cache sees an ordinary busywait memory.
//  Latches the winning request, so the memory sees stable command/address/data for the whole transfer.
//  Arbitration is D-first; if both wait, the grant alternates.
// PARAMETERS
//  ADDR_W   28   block address width (word address >> 2)
//  BLOCK_W  128  block data width (4 x 32-bit words)
// PORTS
//  CLK          in   1        clock, rising edge
//  RESET        in   1        asynchronous, active-low reset
//  I_READ       in   1        I-cache block read request
//  I_ADDRESS    in   ADDR_W   I-cache block address
//  I_READDATA   out  BLOCK_W  block returned to I-cache
//  I_BUSYWAIT   out  1        I-cache stall
//  D_READ       in   1        D-cache block read request
//  D_WRITE      in   1        D-cache block write-back request
//  D_ADDRESS    in   ADDR_W   D-cache block address
//  D_WRITEDATA  in   BLOCK_W  D-cache write-back block
//  D_READDATA   out  BLOCK_W  block returned to D-cache
//  D_BUSYWAIT   out  1        D-cache stall
//  MEM_READ     out  1        memory read command (registered)
//  MEM_WRITE    out  1        memory write command (registered)
//  MEM_ADDRESS  out  ADDR_W   latched address
//  MEM_WRITEDATA out BLOCK_W  latched write block
//  MEM_READDATA in   BLOCK_W  memory read block
//  MEM_BUSYWAIT in   1        memory busy
//  GRANT        out  2        01=I served, 10=D served, 00=idle
// BEHAVIOUR
//  - States: IDLE, SERVE_I, SERVE_D.
//  - A 1-bit FIRST flag marks the first SERVE cycle. A 1-bit LAST_GNT records the last granted requester.
//  - Reset (RESET=0, async, effective immediately, including mid-transfer):
//    - state=IDLE; MEM_READ=MEM_WRITE=0; MEM_ADDRESS=0; MEM_WRITEDATA=0; GRANT=00; LAST_GNT=I.
//    - Any in-flight memory transfer is abandoned.
//  - Request pending: I_REQ = I_READ; D_REQ = D_READ|D_WRITE.
//  - IDLE, at the clock edge:
//    - only D_REQ -> SERVE_D; only I_REQ -> SERVE_I.
//    - both -> SERVE_I if LAST_GNT==D, else SERVE_D.
//    - none -> stay in IDLE.
//  - Grant edge:
//    - latch address (and D_WRITEDATA for D); drive MEM_READ/MEM_WRITE from the next cycle.
//    - set FIRST=1 and update LAST_GNT.
//    - D_READ and D_WRITE both high: the write wins and the read is ignored.
//  - SERVE_x:
//    - MEM_* hold their latched values; requester inputs are ignored until completion.
//    - MEM_BUSYWAIT is ignored while FIRST=1; FIRST clears at the first edge.
//  - Completion cycle = SERVE_x with FIRST=0 and MEM_BUSYWAIT=0. Minimum transfer is 2 cycles.
//    - At the following edge: state goes to IDLE and MEM_READ/MEM_WRITE go to 0.
//    - The requester must drop its request at that same edge.
//    - A request seen in IDLE is always treated as a new transfer.
//  - I_BUSYWAIT = I_READ & ~(state==SERVE_I & ~FIRST & ~MEM_BUSYWAIT). D_BUSYWAIT is analogous with SERVE_D.
//    - Both are combinational; while in reset each equals its request.
//  - I_READDATA and D_READDATA pass MEM_READDATA straight through. They are valid only in the completion cycle.
//  - At least one IDLE cycle separates two transfers, giving the memory a turnaround.
//  - Latency: request in cycle k -> command on MEM_* from cycle k+1 -> earliest completion cycle k+2.
// TESTING
//  T1 reset: RESET=0 during SERVE_D with MEM_WRITE=1 -> MEM_WRITE=0 and GRANT=00 before the next CLK edge.
//  T2 I read, I_ADDRESS=28'h0000010, memory busy 5 cycles, MEM_READDATA=128'hDEADBEEF_0000_1111_2222_3333
//     -> I_BUSYWAIT low for exactly one cycle; I_READDATA matches in that cycle.
//  T3 I_READ and D_READ raised together after reset -> D served first, one IDLE cycle, then I.
//     Raise both again -> D served next (LAST_GNT=I), so grants alternate.
//  T4 D_WRITE to 28'h00000A0 with data 128'h1, D_ADDRESS changed to 28'h00000B0 mid-transfer
//     -> MEM_ADDRESS stays 28'h00000A0 and MEM_WRITEDATA stays 128'h1.
//  T5 D_READ=D_WRITE=1 -> MEM_WRITE=1, MEM_READ=0 for the whole transfer.
//  T6 memory holding MEM_BUSYWAIT=0 in the first SERVE cycle -> no completion; completes one cycle later.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundles the I-cache, D-cache and main-memory block ports around the arbiter.
// master: the arbiter's view (drives cache returns and the memory command).
// slave:  the environment's view (drives cache requests and memory responses).
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W  = 28,
  parameter int unsigned BLOCK_W = 128
);
  // I-cache side (read-only)
  logic               i_read;
  logic [ADDR_W-1:0]  i_address;
  logic [BLOCK_W-1:0] i_readdata;
  logic               i_busywait;
  // D-cache side (read / write-back)
  logic               d_read;
  logic               d_write;
  logic [ADDR_W-1:0]  d_address;
  logic [BLOCK_W-1:0] d_writedata;
  logic [BLOCK_W-1:0] d_readdata;
  logic               d_busywait;
  // Memory side
  logic               mem_read;
  logic               mem_write;
  logic [ADDR_W-1:0]  mem_address;
  logic [BLOCK_W-1:0] mem_writedata;
  logic [BLOCK_W-1:0] mem_readdata;
  logic               mem_busywait;
  // 01 = I served, 10 = D served, 00 = idle
  logic [1:0]         grant;

  modport master (
    input  i_read, i_address, d_read, d_write, d_address, d_writedata,
           mem_readdata, mem_busywait,
    output i_readdata, i_busywait, d_readdata, d_busywait,
           mem_read, mem_write, mem_address, mem_writedata, grant
  );

  modport slave (
    output i_read, i_address, d_read, d_write, d_address, d_writedata,
           mem_readdata, mem_busywait,
    input  i_readdata, i_busywait, d_readdata, d_busywait,
           mem_read, mem_write, mem_address, mem_writedata, grant
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one main-memory block port between the I-cache and the D-cache.
// Each cache sees an ordinary busywait memory. The winning request is latched
// so the memory sees a stable command/address/data for the whole transfer.
// Arbitration prefers D; when both wait in IDLE the grant alternates.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - mem_arbiter_if.master: cache requests/returns, memory command/response, grant
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 28,
  parameter int unsigned BLOCK_W = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.master bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_I    = 2'b01;
  localparam logic [1:0] GNT_D    = 2'b10;

  logic [1:0]         state_q,      state_d;
  logic               first_q,      first_d;      // first SERVE cycle: memory busywait not yet meaningful
  logic               last_gnt_q,   last_gnt_d;   // 1 = D was granted last, 0 = I
  logic               mem_read_q,   mem_read_d;
  logic               mem_write_q,  mem_write_d;
  logic [ADDR_W-1:0]  mem_addr_q,   mem_addr_d;
  logic [BLOCK_W-1:0] mem_wdata_q,  mem_wdata_d;
  logic [1:0]         grant_q,      grant_d;

  logic i_req;
  logic d_req;
  logic i_done;
  logic d_done;

  assign i_req = bus.i_read;
  assign d_req = bus.d_read | bus.d_write;

  // Completion cycle: past the first SERVE cycle and memory no longer busy.
  assign i_done = (state_q == SERVE_I) & ~first_q & ~bus.mem_busywait;
  assign d_done = (state_q == SERVE_D) & ~first_q & ~bus.mem_busywait;

  // Cache-facing stalls and read data are combinational pass-throughs.
  assign bus.i_busywait = bus.i_read & ~i_done;
  assign bus.d_busywait = d_req & ~d_done;
  assign bus.i_readdata = bus.mem_readdata;
  assign bus.d_readdata = bus.mem_readdata;

  assign bus.mem_read      = mem_read_q;
  assign bus.mem_write     = mem_write_q;
  assign bus.mem_address   = mem_addr_q;
  assign bus.mem_writedata = mem_wdata_q;
  assign bus.grant         = grant_q;

  // State and latched-command registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      first_q     <= 1'b0;
      last_gnt_q  <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      grant_q     <= GNT_NONE;
    end else begin
      state_q     <= state_d;
      first_q     <= first_d;
      last_gnt_q  <= last_gnt_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      grant_q     <= grant_d;
    end
  end

  // Arbitration, latching and completion.
  always_comb begin
    state_d     = state_q;
    first_d     = first_q;
    last_gnt_d  = last_gnt_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    grant_d     = grant_q;

    case (state_q)
      IDLE: begin
        // D wins unless both wait and D had the previous grant.
        if (d_req && (!i_req || !last_gnt_q)) begin
          state_d     = SERVE_D;
          first_d     = 1'b1;
          last_gnt_d  = 1'b1;
          mem_addr_d  = bus.d_address;
          mem_wdata_d = bus.d_writedata;
          // A simultaneous read and write-back resolves to the write.
          mem_write_d = bus.d_write;
          mem_read_d  = ~bus.d_write;
          grant_d     = GNT_D;
        end else if (i_req) begin
          state_d     = SERVE_I;
          first_d     = 1'b1;
          last_gnt_d  = 1'b0;
          mem_addr_d  = bus.i_address;
          mem_read_d  = 1'b1;
          mem_write_d = 1'b0;
          grant_d     = GNT_I;
        end
      end
      SERVE_I, SERVE_D: begin
        if (first_q) begin
          first_d = 1'b0;
        end else if (!bus.mem_busywait) begin
          state_d     = IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          grant_d     = GNT_NONE;
        end
      end
      default: begin
        state_d     = IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        grant_d     = GNT_NONE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by randomized cache and
// memory traffic, all compared against a transaction-level reference model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;

  mem_arbiter_if #(.ADDR_W(28), .BLOCK_W(128)) bus ();

  mem_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: who owns the memory, how long it has owned it, and the
  // command it issued.
  int           owner;   // 0 none, 1 I-cache, 2 D-cache
  int           age;     // serve cycles elapsed since the grant
  bit           last_d;  // previous grant went to D
  logic [27:0]  m_addr;
  logic [127:0] m_wdata;
  bit           m_rd;
  bit           m_wr;
  bit           i_done;
  bit           d_done;
  bit           i_cool;
  bit           d_cool;

  // Outputs observed in the most recent cycle.
  logic [1:0]   obs_grant;
  logic         obs_ibw, obs_dbw, obs_rd, obs_wr;
  logic [27:0]  obs_addr;
  logic [127:0] obs_wdata, obs_irdata, obs_drdata;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    owner   = 0;
    age     = 0;
    last_d  = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_rd    = 1'b0;
    m_wr    = 1'b0;
  endfunction

  // Effect of one clock edge on the model, using the inputs held across it.
  function automatic void model_edge();
    bit ireq;
    bit dreq;
    ireq = bus.i_read;
    dreq = bus.d_read | bus.d_write;
    if (owner == 0) begin
      if (dreq && (!ireq || !last_d)) begin
        owner   = 2;
        age     = 0;
        last_d  = 1'b1;
        m_addr  = bus.d_address;
        m_wdata = bus.d_writedata;
        m_wr    = bus.d_write;
        m_rd    = !bus.d_write;
      end else if (ireq) begin
        owner  = 1;
        age    = 0;
        last_d = 1'b0;
        m_addr = bus.i_address;
        m_rd   = 1'b1;
        m_wr   = 1'b0;
      end
    end else if (age >= 1 && !bus.mem_busywait) begin
      owner = 0;
      m_rd  = 1'b0;
      m_wr  = 1'b0;
    end else begin
      age++;
    end
  endfunction

  // One clock cycle: called in the low phase with inputs already set.
  task automatic run_cycle();
    logic [1:0] eg;
    bit         fin;
    #1;
    fin    = (owner != 0) && (age >= 1) && !bus.mem_busywait;
    i_done = fin && (owner == 1);
    d_done = fin && (owner == 2);
    eg = (owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00;
    chk("grant",         128'(bus.grant),     128'(eg));
    chk("mem_read",      128'(bus.mem_read),  128'(m_rd));
    chk("mem_write",     128'(bus.mem_write), 128'(m_wr));
    chk("mem_address",   128'(bus.mem_address), 128'(m_addr));
    chk("mem_writedata", bus.mem_writedata,   m_wdata);
    chk("i_busywait",    128'(bus.i_busywait), 128'(bus.i_read & ~i_done));
    chk("d_busywait",    128'(bus.d_busywait), 128'((bus.d_read | bus.d_write) & ~d_done));
    if (i_done) chk("i_readdata", bus.i_readdata, bus.mem_readdata);
    if (d_done) chk("d_readdata", bus.d_readdata, bus.mem_readdata);
    obs_grant  = bus.grant;
    obs_ibw    = bus.i_busywait;
    obs_dbw    = bus.d_busywait;
    obs_rd     = bus.mem_read;
    obs_wr     = bus.mem_write;
    obs_addr   = bus.mem_address;
    obs_wdata  = bus.mem_writedata;
    obs_irdata = bus.i_readdata;
    obs_drdata = bus.d_readdata;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    // Requesters drop their request once they have seen completion.
    if (i_done) bus.i_read = 1'b0;
    if (d_done) begin
      bus.d_read  = 1'b0;
      bus.d_write = 1'b0;
    end
  endtask

  task automatic apply_reset();
    rst_n            = 1'b0;
    bus.i_read       = 1'b0;
    bus.i_address    = '0;
    bus.d_read       = 1'b0;
    bus.d_write      = 1'b0;
    bus.d_address    = '0;
    bus.d_writedata  = '0;
    bus.mem_readdata = '0;
    bus.mem_busywait = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [1:0] t3_seq [8];
  int         low_cnt;
  int         low_at;
  logic [127:0] rd_at;

  initial begin
    t3_seq[0] = 2'b00; t3_seq[1] = 2'b10; t3_seq[2] = 2'b10; t3_seq[3] = 2'b00;
    t3_seq[4] = 2'b01; t3_seq[5] = 2'b01; t3_seq[6] = 2'b00; t3_seq[7] = 2'b10;
    i_cool = 1'b0;
    d_cool = 1'b0;

    @(negedge clk);
    apply_reset();

    // Reset state
    run_cycle();
    chk("reset_grant", 128'(obs_grant), 128'(2'b00));

    // T1: asynchronous reset in the middle of a D write-back
    bus.d_write      = 1'b1;
    bus.d_address    = 28'h0000123;
    bus.d_writedata  = 128'h55;
    bus.mem_busywait = 1'b1;
    run_cycle();
    run_cycle();
    chk("t1_write_active", 128'(obs_wr), 128'(1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_mem_write",   128'(bus.mem_write),   128'(1'b0));
    chk("t1_grant",       128'(bus.grant),       128'(2'b00));
    chk("t1_mem_address", 128'(bus.mem_address), 128'(28'h0));
    chk("t1_d_busywait",  128'(bus.d_busywait),  128'(1'b1));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    bus.d_write = 1'b0;
    rst_n       = 1'b1;

    // T2: I read, memory busy for five cycles
    apply_reset();
    bus.i_read       = 1'b1;
    bus.i_address    = 28'h0000010;
    bus.mem_readdata = 128'hDEADBEEF_0000_1111_2222_3333;
    low_cnt = 0;
    low_at  = -1;
    rd_at   = '0;
    for (int c = 0; c < 7; c++) begin
      bus.mem_busywait = (c >= 1 && c <= 5);
      run_cycle();
      if (!obs_ibw) begin
        low_cnt++;
        low_at = c;
        rd_at  = obs_irdata;
      end
    end
    chk("t2_low_cycles", 128'(low_cnt), 128'(1));
    chk("t2_low_at",     128'(low_at),  128'(6));
    chk("t2_readdata",   rd_at, 128'hDEADBEEF_0000_1111_2222_3333);
    chk("t2_addr_used",  128'(obs_addr), 128'(28'h0000010));

    // T3: simultaneous requests alternate, D first after reset
    apply_reset();
    bus.i_read    = 1'b1;
    bus.d_read    = 1'b1;
    bus.i_address = 28'h0000200;
    bus.d_address = 28'h0000300;
    for (int c = 0; c < 8; c++) begin
      if (c == 6) begin
        bus.i_read = 1'b1;
        bus.d_read = 1'b1;
      end
      run_cycle();
      chk($sformatf("t3_grant_c%0d", c), 128'(obs_grant), 128'(t3_seq[c]));
    end
    for (int c = 0; c < 8; c++) run_cycle();

    // T4: D write-back keeps its latched address/data
    apply_reset();
    bus.d_write     = 1'b1;
    bus.d_address   = 28'h00000A0;
    bus.d_writedata = 128'h1;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) begin
        bus.d_address   = 28'h00000B0;
        bus.d_writedata = 128'h2;
      end
      bus.mem_busywait = (c >= 1 && c <= 2);
      run_cycle();
      if (c >= 1) begin
        chk("t4_mem_address",   128'(obs_addr), 128'(28'h00000A0));
        chk("t4_mem_writedata", obs_wdata,      128'h1);
      end
    end

    // T5: read and write together resolve to a write
    apply_reset();
    bus.d_read  = 1'b1;
    bus.d_write = 1'b1;
    for (int c = 0; c < 3; c++) begin
      run_cycle();
      if (c >= 1) begin
        chk("t5_mem_write", 128'(obs_wr), 128'(1'b1));
        chk("t5_mem_read",  128'(obs_rd), 128'(1'b0));
      end
    end

    // T6: memory not busy at all -> completes in the second serve cycle
    apply_reset();
    bus.d_read = 1'b1;
    run_cycle();
    run_cycle();
    chk("t6_first_cycle_busy", 128'(obs_dbw), 128'(1'b1));
    run_cycle();
    chk("t6_completes",        128'(obs_dbw), 128'(1'b0));
    run_cycle();

    // Randomized traffic from both caches against a random-latency memory
    apply_reset();
    for (int n = 0; n < 600; n++) begin
      if (!bus.i_read && !i_cool && $urandom_range(0, 2) == 0) bus.i_read = 1'b1;
      if (!bus.d_read && !bus.d_write && !d_cool && $urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 2))
          0:       bus.d_read = 1'b1;
          1:       bus.d_write = 1'b1;
          default: begin
            bus.d_read  = 1'b1;
            bus.d_write = 1'b1;
          end
        endcase
      end
      bus.i_address    = 28'($urandom);
      bus.d_address    = 28'($urandom);
      bus.d_writedata  = {$urandom, $urandom, $urandom, $urandom};
      bus.mem_readdata = {$urandom, $urandom, $urandom, $urandom};
      bus.mem_busywait = ($urandom_range(0, 2) != 0);
      run_cycle();
      i_cool = i_done;
      d_cool = d_done;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
